// File: rtl/find_max_timing_seq.sv
// Sequential max-timing selector: scans N_AXES motion profiles one per clock and latches the
// enabled axis with the largest key timing word (lowest index wins ties).
module find_max_timing_seq #(
    parameter int unsigned N_AXES   = 5,
    parameter int unsigned N_PARAMS = 5,
    parameter int unsigned N_TIMING = 4,
    parameter int unsigned PW       = 32,
    parameter int unsigned TW       = 64,
    parameter int unsigned KEY_IDX  = 3,
    localparam int unsigned IW      = (N_AXES > 1) ? $clog2(N_AXES) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [N_AXES-1:0]            axis_en,
    input  logic [N_AXES*N_PARAMS*PW-1:0] params_in,
    input  logic [N_AXES*N_TIMING*TW-1:0] timing_in,
    output logic [N_PARAMS*PW-1:0]       max_params,
    output logic [N_TIMING*TW-1:0]       max_timing,
    output logic [IW-1:0]                max_index,
    output logic                         none_valid,
    output logic                         busy,
    output logic                         finish
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    localparam logic [IW-1:0] LastIdx = IW'(N_AXES - 1);

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   found_q, found_d;
    logic [TW-1:0]          best_q, best_d;
    logic [N_PARAMS*PW-1:0] params_q, params_d;
    logic [N_TIMING*TW-1:0] timing_q, timing_d;
    logic [IW-1:0]          index_q, index_d;
    logic                   none_q, none_d;

    logic [N_PARAMS*PW-1:0] cur_params;
    logic [N_TIMING*TW-1:0] cur_timing;
    logic [TW-1:0]          cur_key;

    assign cur_params = params_in[32'(idx_q)*N_PARAMS*PW +: N_PARAMS*PW];
    assign cur_timing = timing_in[32'(idx_q)*N_TIMING*TW +: N_TIMING*TW];
    assign cur_key    = timing_in[(32'(idx_q)*N_TIMING + KEY_IDX)*TW +: TW];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            found_q  <= 1'b0;
            best_q   <= '0;
            params_q <= '0;
            timing_q <= '0;
            index_q  <= '0;
            none_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            found_q  <= found_d;
            best_q   <= best_d;
            params_q <= params_d;
            timing_q <= timing_d;
            index_q  <= index_d;
            none_q   <= none_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        found_d  = found_q;
        best_d   = best_q;
        params_d = params_q;
        timing_d = timing_q;
        index_d  = index_q;
        none_d   = none_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StScan;
                    idx_d   = '0;
                    found_d = 1'b0;
                end
            end
            StScan: begin
                // Strict compare keeps the lowest enabled index on ties.
                if (axis_en[idx_q] && (!found_q || cur_key > best_q)) begin
                    params_d = cur_params;
                    timing_d = cur_timing;
                    index_d  = idx_q;
                    best_d   = cur_key;
                    found_d  = 1'b1;
                end
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                    none_d  = ~found_d;
                    if (!found_d) begin
                        params_d = '0;
                        timing_d = '0;
                        index_d  = '0;
                    end
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign max_params = params_q;
    assign max_timing = timing_q;
    assign max_index  = index_q;
    assign none_valid = none_q;
    assign busy       = (state_q == StScan);
    assign finish     = (state_q == StDone);

endmodule

// File: tb/tb_find_max_timing_seq.sv
// Self-checking bench for find_max_timing_seq: directed cases on a 5-axis instance and a
// randomized reference-model comparison on an 8-axis instance keyed on timing word 0.
module tb_find_max_timing_seq;

    localparam int N0 = 5;
    localparam int N1 = 8;
    localparam int NP = 5;
    localparam int NT = 4;
    localparam int PW = 32;
    localparam int TW = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                 start0;
    logic [N0-1:0]        en0;
    logic [N0*NP*PW-1:0]  params0;
    logic [N0*NT*TW-1:0]  timing0;
    logic [NP*PW-1:0]     mp0;
    logic [NT*TW-1:0]     mt0;
    logic [2:0]           mi0;
    logic                 nv0, busy0, fin0;

    logic                 start1;
    logic [N1-1:0]        en1;
    logic [N1*NP*PW-1:0]  params1;
    logic [N1*NT*TW-1:0]  timing1;
    logic [NP*PW-1:0]     mp1;
    logic [NT*TW-1:0]     mt1;
    logic [2:0]           mi1;
    logic                 nv1, busy1, fin1;

    find_max_timing_seq #(.N_AXES(N0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .axis_en(en0),
        .params_in(params0), .timing_in(timing0), .max_params(mp0), .max_timing(mt0),
        .max_index(mi0), .none_valid(nv0), .busy(busy0), .finish(fin0)
    );

    find_max_timing_seq #(.N_AXES(N1), .KEY_IDX(0)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .axis_en(en1),
        .params_in(params1), .timing_in(timing1), .max_params(mp1), .max_timing(mt1),
        .max_index(mi1), .none_valid(nv1), .busy(busy1), .finish(fin1)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill0();
        for (int i = 0; i < N0*NP; i++) params0[i*PW +: PW] = $urandom;
        for (int i = 0; i < N0*NT; i++) timing0[i*TW +: TW] = {$urandom, $urandom};
    endtask

    task automatic key0(input int a, input logic [TW-1:0] k);
        timing0[(a*NT+3)*TW +: TW] = k;
    endtask

    // j=0 is the cycle after start is accepted; restart_at re-pulses start at that sample.
    task automatic scan0(input int restart_at, output int fin_at, output int nfin,
                         output int nbusy);
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        fin_at = -1; nfin = 0; nbusy = 0;
        for (int j = 0; j < 2*N0+6; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            if (busy0) nbusy++;
            if (fin0) begin nfin++; if (fin_at < 0) fin_at = j; end
            start0 = (j == restart_at);
        end
        start0 = 1'b0;
    endtask

    task automatic scan1(output int fin_at, output int nfin, output int nbusy);
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        fin_at = -1; nfin = 0; nbusy = 0;
        for (int j = 0; j < N1+3; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            if (busy1) nbusy++;
            if (fin1) begin nfin++; if (fin_at < 0) fin_at = j; end
        end
    endtask

    // Reference: highest key among enabled axes, first one found wins ties.
    task automatic expect0(input string tag);
        int win = -1;
        logic [TW-1:0] bk = '0;
        for (int a = 0; a < N0; a++) begin
            if (en0[a] && (win < 0 || timing0[(a*NT+3)*TW +: TW] > bk)) begin
                win = a; bk = timing0[(a*NT+3)*TW +: TW];
            end
        end
        check({tag, ".nv"}, 512'(nv0), 512'(win < 0));
        check({tag, ".idx"}, 512'(mi0), (win < 0) ? 512'(0) : 512'(win));
        check({tag, ".par"}, 512'(mp0), (win < 0) ? 512'(0) : 512'(params0[win*NP*PW +: NP*PW]));
        check({tag, ".tim"}, 512'(mt0), (win < 0) ? 512'(0) : 512'(timing0[win*NT*TW +: NT*TW]));
    endtask

    int fin_at, nfin, nbusy, w1;
    logic [TW-1:0] bk1, k1;

    initial begin
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
        en0 = '0; en1 = '0; params0 = '0; timing0 = '0; params1 = '0; timing1 = '0;
        repeat (3) @(posedge clk);
        #1; reset = 1'b0;
        check("rst.par", 512'(mp0), 512'(0));
        check("rst.tim", 512'(mt0), 512'(0));
        check("rst.idx", 512'(mi0), 512'(0));
        check("rst.nv_busy_fin", 512'({nv0, busy0, fin0}), 512'(0));

        // Main function, with a tie between y and e0.
        fill0(); en0 = '1;
        key0(0, 100); key0(1, 250); key0(2, 40); key0(3, 250); key0(4, 7);
        scan0(-1, fin_at, nfin, nbusy);
        check("basic.lat", 512'(fin_at), 512'(N0));
        check("basic.nfin", 512'(nfin), 512'(1));
        check("basic.busy", 512'(nbusy), 512'(N0));
        check("basic.idx1", 512'(mi0), 512'(1));
        expect0("basic");

        // Reset mid-scan.
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        check("abort.par", 512'(mp0), 512'(0));
        check("abort.tim", 512'(mt0), 512'(0));
        check("abort.idx_nv_busy", 512'({mi0, nv0, busy0}), 512'(0));
        nfin = 0;
        repeat (10) begin @(posedge clk); #1; if (fin0) nfin++; end
        check("abort.nofin", 512'(nfin), 512'(0));

        // Ties.
        fill0(); en0 = '1;
        for (int a = 0; a < N0; a++) key0(a, 500);
        scan0(-1, fin_at, nfin, nbusy);
        check("tie.idx0", 512'(mi0), 512'(0));
        expect0("tie");
        en0 = 5'b11100;
        scan0(-1, fin_at, nfin, nbusy);
        check("tie.idx2", 512'(mi0), 512'(2));
        expect0("tie_en");

        // All keys zero, some enabled.
        for (int a = 0; a < N0; a++) key0(a, 0);
        en0 = 5'b01010;
        scan0(-1, fin_at, nfin, nbusy);
        check("zero.idx", 512'(mi0), 512'(1));
        expect0("zero");

        // Nothing enabled.
        fill0(); en0 = '0;
        scan0(-1, fin_at, nfin, nbusy);
        check("none.lat", 512'(fin_at), 512'(N0));
        check("none.nv", 512'(nv0), 512'(1));
        expect0("none");

        // Full-width unsigned keys, with an ignored start while busy.
        fill0(); en0 = '1;
        key0(0, 64'h8000_0000_0000_0000); key0(1, 5); key0(2, 64'h7FFF_FFFF_FFFF_FFFF);
        key0(3, 0); key0(4, 64'hFFFF_FFFF_FFFF_FFFF);
        scan0(2, fin_at, nfin, nbusy);
        check("wide.idx", 512'(mi0), 512'(4));
        check("wide.nfin", 512'(nfin), 512'(1));
        check("wide.lat", 512'(fin_at), 512'(N0));
        check("wide.busy", 512'(nbusy), 512'(N0));
        expect0("wide");

        // Randomized scans on the 8-axis instance.
        for (int s = 0; s < 1000; s++) begin
            en1 = ($urandom_range(0, 15) == 0) ? '0 : N1'($urandom);
            for (int i = 0; i < N1*NP; i++) params1[i*PW +: PW] = $urandom;
            for (int a = 0; a < N1; a++) begin
                for (int w = 0; w < NT; w++) timing1[(a*NT+w)*TW +: TW] = {$urandom, $urandom};
                if (s % 2 == 0) timing1[(a*NT)*TW +: TW] = 64'($urandom_range(0, 3));
            end
            scan1(fin_at, nfin, nbusy);
            w1 = -1; bk1 = '0;
            for (int a = 0; a < N1; a++) begin
                k1 = timing1[(a*NT)*TW +: TW];
                if (en1[a] && (w1 < 0 || k1 > bk1)) begin w1 = a; bk1 = k1; end
            end
            check("rnd.lat", 512'(fin_at), 512'(N1));
            check("rnd.busy", 512'(nbusy), 512'(N1));
            check("rnd.nv", 512'(nv1), 512'(w1 < 0));
            check("rnd.idx", 512'(mi1), (w1 < 0) ? 512'(0) : 512'(w1));
            check("rnd.par", 512'(mp1), (w1 < 0) ? 512'(0) : 512'(params1[w1*NP*PW +: NP*PW]));
            check("rnd.tim", 512'(mt1), (w1 < 0) ? 512'(0) : 512'(timing1[w1*NT*TW +: NT*TW]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
